// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: fetch, decode, execute, memory and write-back sequencing.
// Latency with zero-wait memory: J/JAL/JR 2, branch 3, ALU/store 4, load 5 cycles; +1 per wait cycle.
// Memory backpressure: mem_req held until mem_ready; bounded wait traps with cause 2.
module mips_multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 6,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          reg_src,
  output logic                alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_src,
  output logic                branch_eq,
  output logic                branch_ne,
  output logic [1:0]          apply_mask,
  output logic [2:0]          state,
  output logic [1:0]          trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_R, CL_ALUI, CL_BEQ, CL_BNE, CL_LOAD, CL_STORE,
    CL_J, CL_JAL, CL_JR, CL_ILLEGAL
  } cls_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'h03);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_ADDIU = OPCODE_W'(6'h09);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'h0A);
  localparam logic [OPCODE_W-1:0] OP_SLTIU = OPCODE_W'(6'h0B);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'h0C);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'h0D);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'h0F);
  localparam logic [OPCODE_W-1:0] OP_LB    = OPCODE_W'(6'h20);
  localparam logic [OPCODE_W-1:0] OP_LH    = OPCODE_W'(6'h21);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_LBU   = OPCODE_W'(6'h24);
  localparam logic [OPCODE_W-1:0] OP_LHU   = OPCODE_W'(6'h25);
  localparam logic [OPCODE_W-1:0] OP_SB    = OPCODE_W'(6'h28);
  localparam logic [OPCODE_W-1:0] OP_SH    = OPCODE_W'(6'h29);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);
  localparam logic [5:0]          FN_JR    = 6'h08;

  // Counter only has to reach TIMEOUT-1; keep at least one bit when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              st_q;
  cls_t                cls_q;
  cls_t                dec_cls;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    wait_q;
  logic [1:0]          cause_q;
  logic                timeout_hit;
  logic [1:0]          size_mask;

  function automatic cls_t classify(input logic [OPCODE_W-1:0] op, input logic [5:0] fn);
    cls_t c;
    c = CL_ILLEGAL;
    case (op)
      OP_RTYPE: c = (fn == FN_JR) ? CL_JR : CL_R;
      OP_J:     c = CL_J;
      OP_JAL:   c = CL_JAL;
      OP_BEQ:   c = CL_BEQ;
      OP_BNE:   c = CL_BNE;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: c = CL_ALUI;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: c = CL_LOAD;
      OP_SB, OP_SH, OP_SW: c = CL_STORE;
      default:  c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

  // Classify the live IR opcode; only consumed in DECODE.
  always_comb begin
    dec_cls = classify(opcode, funct);
  end

  // Access size of the registered load/store opcode.
  always_comb begin
    size_mask = 2'd0;
    case (op_q)
      OP_LB, OP_LBU, OP_SB: size_mask = 2'd2;
      OP_LH, OP_LHU, OP_SH: size_mask = 2'd1;
      default:              size_mask = 2'd0;
    endcase
  end

  // Last allowed wait cycle with memory still not ready; a ready in that cycle completes normally.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_LAST) && !mem_ready;
  end

  // State sequencing, instruction class capture, wait counter and trap cause.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      st_q    <= S_FETCH;
      cls_q   <= CL_NONE;
      op_q    <= '0;
      wait_q  <= '0;
      cause_q <= 2'd0;
    end else begin
      wait_q <= '0;
      case (st_q)
        S_FETCH: begin
          if (mem_ready) begin
            st_q <= S_DECODE;
          end else if (timeout_hit) begin
            st_q    <= S_TRAP;
            cause_q <= 2'd2;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
          cls_q <= dec_cls;
          op_q  <= opcode;
          case (dec_cls)
            CL_ILLEGAL: begin
              st_q    <= S_TRAP;
              cause_q <= 2'd1;
            end
            CL_J, CL_JAL, CL_JR: st_q <= S_FETCH;
            default:             st_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            CL_BEQ, CL_BNE:    st_q <= S_FETCH;
            CL_LOAD, CL_STORE: st_q <= S_MEM;
            default:           st_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            st_q <= (cls_q == CL_STORE) ? S_FETCH : S_WB;
          end else if (timeout_hit) begin
            st_q    <= S_TRAP;
            cause_q <= 2'd2;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        S_WB:    st_q <= S_FETCH;
        S_TRAP:  st_q <= S_TRAP;
        default: st_q <= S_FETCH;
      endcase
    end
  end

  // Control outputs decoded from state and class; forced low while reset is held.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_src    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    reg_src    = 2'd0;
    alu_src_b  = 1'b0;
    alu_op     = '0;
    pc_src     = 2'd0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    apply_mask = 2'd0;
    state      = 3'd0;
    trap       = 2'd0;
    if (nrst) begin
      state = st_q;
      case (st_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          pc_write = mem_ready;
          ir_write = mem_ready;
        end
        S_DECODE: begin
          case (dec_cls)
            CL_J: begin
              pc_write = 1'b1;
              pc_src   = 2'd2;
            end
            CL_JAL: begin
              pc_write  = 1'b1;
              pc_src    = 2'd2;
              reg_write = 1'b1;
              reg_dst   = 2'd2;
              reg_src   = 2'd2;
            end
            CL_JR: begin
              pc_write = 1'b1;
              pc_src   = 2'd3;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            CL_R: alu_op = ALUOP_W'(6'h02);
            CL_ALUI: begin
              alu_src_b = 1'b1;
              alu_op    = (op_q == OP_ADDI) ? '0 : ALUOP_W'(op_q);
            end
            CL_LOAD, CL_STORE: alu_src_b = 1'b1;
            CL_BEQ: begin
              alu_op    = ALUOP_W'(6'h01);
              pc_write  = 1'b1;
              pc_src    = 2'd1;
              branch_eq = 1'b1;
            end
            CL_BNE: begin
              alu_op    = ALUOP_W'(6'h01);
              pc_write  = 1'b1;
              pc_src    = 2'd1;
              branch_ne = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req    = 1'b1;
          mem_src    = 1'b1;
          alu_src_b  = 1'b1;
          apply_mask = size_mask;
          mem_we     = (cls_q == CL_STORE);
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (cls_q == CL_R) ? 2'd1 : 2'd0;
          reg_src    = (cls_q == CL_LOAD) ? 2'd1 : 2'd0;
          apply_mask = (cls_q == CL_LOAD) ? size_mask : 2'd0;
        end
        S_TRAP:  trap = cause_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control FSM; small memory timeout so the trap path is short.
module tb_mips_multicycle_control;

  logic       clk;
  logic       nrst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_req, mem_we, mem_src, reg_write;
  logic [1:0] reg_dst, reg_src;
  logic       alu_src_b;
  logic [5:0] alu_op;
  logic [1:0] pc_src;
  logic       branch_eq, branch_ne;
  logic [1:0] apply_mask;
  logic [2:0] state;
  logic [1:0] trap;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control #(.OPCODE_W(6), .ALUOP_W(6), .TIMEOUT(4)) dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_src(mem_src), .reg_write(reg_write), .reg_dst(reg_dst), .reg_src(reg_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .apply_mask(apply_mask), .state(state), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected field order: state trap | pcw irw req we msrc | rw rdst rsrc | asb aop | psrc beq bne | mask
  task automatic expect_out(input string tag, input int st, input int tr,
                            input int pcw, input int irw, input int req, input int we, input int msrc,
                            input int rw, input int rdst, input int rsrc,
                            input int asb, input int aop,
                            input int psrc, input int beq, input int bne, input int mask);
    logic [27:0] got;
    logic [27:0] want;
    #1;
    got  = {state, trap, pc_write, ir_write, mem_req, mem_we, mem_src, reg_write, reg_dst, reg_src,
            alu_src_b, alu_op, pc_src, branch_eq, branch_ne, apply_mask};
    want = {3'(st), 2'(tr), 1'(pcw), 1'(irw), 1'(req), 1'(we), 1'(msrc), 1'(rw), 2'(rdst), 2'(rsrc),
            1'(asb), 6'(aop), 2'(psrc), 1'(beq), 1'(bne), 2'(mask)};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %07h expected %07h", tag, got, want);
    end
  endtask

  task automatic fetch(input string tag, input int rdy);
    expect_out(tag, 0, 0, rdy, rdy, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic quiet(input string tag, input int st, input int tr);
    expect_out(tag, st, tr, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    nrst = 1'b0; opcode = 6'h00; funct = 6'h00; mem_ready = 1'b0;
    quiet("reset_comb", 0, 0);
    tick(); quiet("reset_edge", 0, 0);
    nrst = 1'b1; fetch("fetch_wait", 0);

    // R-type add: F D E WB
    mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; fetch("r_fetch", 1);
    tick(); quiet("r_decode", 1, 0);
    tick(); expect_out("r_exec", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    tick(); expect_out("r_wb", 4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // LB with three wait cycles; ready arrives on the last allowed wait count
    tick(); opcode = 6'h20; funct = 6'h00; fetch("lb_fetch", 1);
    tick(); quiet("lb_decode", 1, 0);
    tick(); mem_ready = 1'b0; expect_out("lb_exec", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out($sformatf("lb_mem_wait%0d", i), 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    end
    tick(); mem_ready = 1'b1; expect_out("lb_mem_ready", 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    tick(); expect_out("lb_wb", 4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2);

    // BNE and BEQ
    tick(); opcode = 6'h05; fetch("bne_fetch", 1);
    tick(); quiet("bne_decode", 1, 0);
    tick(); expect_out("bne_exec", 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    tick(); opcode = 6'h04; fetch("beq_fetch", 1);
    tick(); quiet("beq_decode", 1, 0);
    tick(); expect_out("beq_exec", 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);

    // ORI: alu_op carries the opcode
    tick(); opcode = 6'h0D; fetch("ori_fetch", 1);
    tick(); quiet("ori_decode", 1, 0);
    tick(); expect_out("ori_exec", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0);
    tick(); expect_out("ori_wb", 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // JAL and JR complete in DECODE
    tick(); opcode = 6'h03; fetch("jal_fetch", 1);
    tick(); expect_out("jal_decode", 1, 0, 1, 0, 0, 0, 0, 1, 2, 2, 0, 0, 2, 0, 0, 0);
    tick(); opcode = 6'h00; funct = 6'h08; fetch("jr_fetch", 1);
    tick(); expect_out("jr_decode", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

    // SH, zero-wait store
    tick(); opcode = 6'h29; funct = 6'h00; fetch("sh_fetch", 1);
    tick(); quiet("sh_decode", 1, 0);
    tick(); expect_out("sh_exec", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick(); expect_out("sh_mem", 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    // Illegal opcode traps and holds until reset
    tick(); opcode = 6'h3F; fetch("ill_fetch", 1);
    tick(); quiet("ill_decode", 1, 0);
    tick(); quiet("ill_trap", 5, 1);
    tick(); quiet("ill_trap_hold", 5, 1);
    nrst = 1'b0; quiet("ill_rst_comb", 0, 0);
    tick(); quiet("ill_rst_edge", 0, 0);

    // Fetch timeout: four unanswered request cycles, then trap cause 2
    nrst = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20;
    fetch("to_wait0", 0);
    tick(); fetch("to_wait1", 0);
    tick(); fetch("to_wait2", 0);
    tick(); fetch("to_wait3", 0);
    tick(); quiet("to_trap", 5, 2);
    tick(); quiet("to_trap_hold", 5, 2);
    nrst = 1'b0; quiet("to_rst_comb", 0, 0);
    tick(); quiet("to_rst_edge", 0, 0);
    nrst = 1'b1; fetch("to_rst_fetch", 0);

    // SW interrupted by reset during its memory wait
    mem_ready = 1'b1; opcode = 6'h2B; fetch("sw_fetch", 1);
    tick(); quiet("sw_decode", 1, 0);
    tick(); mem_ready = 1'b0; expect_out("sw_exec", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick(); expect_out("sw_mem_wait", 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    nrst = 1'b0; quiet("sw_rst_comb", 0, 0);
    tick(); quiet("sw_rst_edge", 0, 0);
    nrst = 1'b1; fetch("sw_after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
